// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the multicycle CPU phase sequencer: state encoding,
// one-hot phase enables and the default PC increment.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_READ  = 3'd1,
      ST_MEM   = 3'd2,
      ST_WB    = 3'd3,
      ST_HALT  = 3'd4,
      ST_FAULT = 3'd5
   } state_e;

   localparam int PH_W = 4;

   // Bit order matches {ph_wb, ph_mem, ph_read, ph_fetch}.
   localparam logic [PH_W-1:0] PH_NONE  = 4'b0000;
   localparam logic [PH_W-1:0] PH_FETCH = 4'b0001;
   localparam logic [PH_W-1:0] PH_READ  = 4'b0010;
   localparam logic [PH_W-1:0] PH_MEM   = 4'b0100;
   localparam logic [PH_W-1:0] PH_WB    = 4'b1000;

   localparam int PC_STEP_DEFAULT = 4;

   function automatic logic [PH_W-1:0] phase_of(state_e st);
      logic [PH_W-1:0] ph;
      ph = PH_NONE;
      case (st)
         ST_FETCH: ph = PH_FETCH;
         ST_READ:  ph = PH_READ;
         ST_MEM:   ph = PH_MEM;
         ST_WB:    ph = PH_WB;
         default:  ph = PH_NONE;
      endcase
      return ph;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the phase sequencer (master) and the decoder, register
// file and memories (slave).
interface multicycle_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
);
   logic              halt_i;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic              is_mem;
   logic              is_branch;
   logic              br_taken;
   logic              is_link;
   logic [ADDR_W-1:0] br_target;
   logic              dmem_req;
   logic              dmem_ack;
   logic              ph_fetch;
   logic              ph_read;
   logic              ph_mem;
   logic              ph_wb;
   logic              rf_we;
   logic              lr_we;
   logic [ADDR_W-1:0] lr_data;
   logic [ADDR_W-1:0] pc;
   logic              halted;
   logic              fault;
   logic [CNT_W-1:0]  retired_cnt;

   modport master (
      input  halt_i, imem_ack, is_mem, is_branch, br_taken, is_link,
             br_target, dmem_ack,
      output imem_req, imem_addr, dmem_req, ph_fetch, ph_read, ph_mem,
             ph_wb, rf_we, lr_we, lr_data, pc, halted, fault, retired_cnt
   );

   modport slave (
      output halt_i, imem_ack, is_mem, is_branch, br_taken, is_link,
             br_target, dmem_ack,
      input  imem_req, imem_addr, dmem_req, ph_fetch, ph_read, ph_mem,
             ph_wb, rf_we, lr_we, lr_data, pc, halted, fault, retired_cnt
   );

endinterface

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter shared by instruction fetch and data access; flags
// expiry once a request has gone TIMEOUT cycles without acknowledge.
module mem_wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic nreset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   logic [CW-1:0] cnt_q, cnt_d;

   // Holds at the limit so the counter never wraps back below expiry.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Handshaked FETCH/READ/MEM/WB phase sequencer: owns the PC, link value,
// halt/fault parking and the retired-instruction counter.
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] PC_RESET = '0,
   parameter int                PC_STEP  = PC_STEP_DEFAULT,
   parameter int                SKIP_MEM = 1,
   parameter int                TIMEOUT  = 15,
   parameter int                CNT_W    = 32
) (
   input  logic             clk,
   input  logic             nreset,
   multicycle_ctrl_if.master bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] target_q, target_d;
   logic [CNT_W-1:0]  ret_q, ret_d;
   logic              mem_q, mem_d;
   logic              taken_q, taken_d;
   logic              link_q, link_d;

   logic [ADDR_W-1:0] pc_inc;
   logic              wait_act;
   logic              ack_sel;
   logic              tmr_clr;
   logic              tmr_en;
   logic              tmr_exp;
   logic [PH_W-1:0]   phase;

   assign pc_inc = pc_q + ADDR_W'(PC_STEP);

   // Only FETCH and a real data access wait on a handshake; any other
   // state, or an arriving ack, restarts the timer for the next wait.
   assign wait_act = (state_q == ST_FETCH) || ((state_q == ST_MEM) && mem_q);
   assign ack_sel  = (state_q == ST_FETCH) ? bus.imem_ack : bus.dmem_ack;
   assign tmr_clr  = !wait_act || ack_sel;
   assign tmr_en   = wait_act && !ack_sel;

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .nreset    (nreset),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (tmr_exp)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ret_d    = ret_q;
      mem_d    = mem_q;
      taken_d  = taken_q;
      link_d   = link_q;
      target_d = target_q;
      unique case (state_q)
         ST_FETCH: begin
            // Ack is tested first so a same-cycle ack beats expiry.
            if (bus.imem_ack) begin
               state_d = ST_READ;
            end else if (tmr_exp) begin
               state_d = ST_FAULT;
            end
         end
         ST_READ: begin
            mem_d    = bus.is_mem;
            taken_d  = bus.is_branch && bus.br_taken;
            link_d   = bus.is_link;
            target_d = bus.br_target;
            if ((SKIP_MEM != 0) && !bus.is_mem) begin
               state_d = ST_WB;
            end else begin
               state_d = ST_MEM;
            end
         end
         ST_MEM: begin
            if (!mem_q || bus.dmem_ack) begin
               state_d = ST_WB;
            end else if (tmr_exp) begin
               state_d = ST_FAULT;
            end
         end
         ST_WB: begin
            pc_d    = taken_q ? target_q : pc_inc;
            ret_d   = ret_q + CNT_W'(1);
            state_d = bus.halt_i ? ST_HALT : ST_FETCH;
         end
         ST_HALT: begin
            if (!bus.halt_i) begin
               state_d = ST_FETCH;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q  <= ST_FETCH;
         pc_q     <= PC_RESET;
         ret_q    <= '0;
         mem_q    <= 1'b0;
         taken_q  <= 1'b0;
         link_q   <= 1'b0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ret_q    <= ret_d;
         mem_q    <= mem_d;
         taken_q  <= taken_d;
         link_q   <= link_d;
         target_q <= target_d;
      end
   end

   assign phase = phase_of(state_q);

   assign bus.ph_fetch    = phase[0];
   assign bus.ph_read     = phase[1];
   assign bus.ph_mem      = phase[2];
   assign bus.ph_wb       = phase[3];
   assign bus.rf_we       = phase[3];
   assign bus.imem_req    = (state_q == ST_FETCH);
   assign bus.imem_addr   = pc_q;
   assign bus.dmem_req    = (state_q == ST_MEM) && mem_q;
   assign bus.lr_we       = (state_q == ST_WB) && taken_q && link_q;
   assign bus.lr_data     = pc_inc;
   assign bus.pc          = pc_q;
   assign bus.halted      = (state_q == ST_HALT);
   assign bus.fault       = (state_q == ST_FAULT);
   assign bus.retired_cnt = ret_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Parametrised phase sequencer for the multicycle CPU. It replaces the fixed 4-phase cycle counter with a handshaked FSM: FETCH, READ, MEM, WB. It generates one-hot phase enables for the decoder, register file and memory file, owns PC and next-PC/link computation, waits on memory ready, and optionally skips MEM for non-memory instructions. It adds halt, memory timeout fault, and a retired-instruction counter.

Parameters:
ADDR_W, 32, PC and address width
PC_RESET, 0, PC value after reset
PC_STEP, 4, PC increment per sequential instruction
SKIP_MEM, 1, 1: non-memory instructions bypass MEM; 0: legacy fixed 4-phase sequence
TIMEOUT, 15, max cycles a memory request waits for ack before fault; 0 disables the timeout
CNT_W, 32, retired counter width

Ports:
clk  in  1  clock; all state on rising edge
nreset  in  1  asynchronous active-low reset
halt_i  in  1  request stop at next instruction boundary
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address (= pc)
imem_ack  in  1  fetch data valid; may be combinational in the same cycle as req
is_mem  in  1  decoded LDR/STR; sampled in READ
is_branch  in  1  decoded branch; sampled in READ
br_taken  in  1  branch condition passed; sampled in READ
is_link  in  1  branch-and-link; sampled in READ
br_target  in  ADDR_W  branch target; sampled in READ
dmem_req  out  1  data memory request
dmem_ack  in  1  data access complete
ph_fetch, ph_read, ph_mem, ph_wb  out  1 each  one-hot phase enables
rf_we  out  1  register write enable (= ph_wb)
lr_we  out  1  R14 write enable
lr_data  out  ADDR_W  return address for R14
pc  out  ADDR_W  current PC
halted  out  1  sequencer parked
fault  out  1  sticky memory timeout
retired_cnt  out  CNT_W  completed instructions

Behaviour:
- States: FETCH, READ, MEM, WB, HALT, FAULT. Async reset sets state=FETCH, pc=PC_RESET, retired_cnt=0, latches=0, wait counter=0. Outputs follow immediately, with no clock edge needed.
- Reset output values: imem_req=1 (FETCH), imem_addr=PC_RESET, ph_fetch=1, all other strobes 0, halted=0, fault=0.
- FETCH: imem_req=1, ph_fetch=1.
  - imem_ack=1 -> READ next edge, wait counter cleared.
  - Otherwise wait counter increments. If TIMEOUT!=0 and counter reaches TIMEOUT-1 with no ack -> FAULT.
- READ: one cycle, ph_read=1. Latch is_mem, is_branch&br_taken, is_link, br_target.
  - SKIP_MEM=1 and !is_mem -> WB.
  - Otherwise -> MEM.
- MEM: ph_mem=1.
  - dmem_req=latched is_mem.
  - If is_mem: wait for dmem_ack with the same timeout rule as FETCH.
  - If !is_mem (SKIP_MEM=0): one cycle, no request.
- WB: one cycle, ph_wb=1, rf_we=1.
  - pc <= taken ? br_target : pc+PC_STEP, modulo 2^ADDR_W.
  - lr_we=taken&is_link; lr_data=pc+PC_STEP (old pc).
  - retired_cnt++ (wraps).
  - halt_i=1 -> HALT, else FETCH.
- HALT: halted=1, all strobes 0. halt_i=0 -> FETCH next edge. halt_i is only sampled in WB and HALT.
- FAULT: fault=1, all strobes 0, pc frozen. Exit only by nreset.
- ack inputs are ignored outside their own request state. An ack in the same cycle as the timeout expiry wins (no fault).
- Latency with zero-wait memory: 3 cycles for a non-memory instruction (SKIP_MEM=1), 4 cycles for memory instructions or SKIP_MEM=0.
- No alignment checking on br_target.

Decomposition:
- Package cpu_ctrl_pkg: state enum, phase one-hot encoding constants, PC_STEP default.
- One sub-module, mem_wait_timer: clear/enable/expired, parametrised by TIMEOUT, shared by FETCH and MEM.

Test Plan:
- SKIP_MEM=1, imem_ack tied 1, three ALU ops -> imem_addr 0x0, 0x4, 0x8 at cycles 0, 3, 6; retired_cnt=3 at cycle 9. With SKIP_MEM=0 the same program takes 4 cycles per op.
- LDR with dmem_ack delayed 2 cycles -> dmem_req high 3 cycles, instruction spans 6 cycles, pc advances to +4 only after ack.
- BL at pc=0x10, taken, target 0x40 -> in WB lr_we=1, lr_data=0x14; next imem_addr=0x40. Same instruction not taken -> lr_we=0, next 0x14.
- TIMEOUT=4, imem_ack held 0 -> fault=1 after 4 FETCH cycles; strobes 0 and fault stays set for 20 cycles until nreset pulse.
- halt_i raised during READ -> instruction completes WB, halted=1, pc=next. Drop halt_i -> FETCH next edge with the same pc.
- nreset low mid-MEM wait, off clock edge -> pc=PC_RESET, dmem_req=0, ph_fetch=1 immediately; retired_cnt=0.
